// File: rtl/box_drawer_if.sv
// Box-draw command channel plus the pixel write port toward the VGA adapter.
interface box_drawer_if;
    logic       s_ready;
    logic       s_valid;
    logic [8:0] in_box_x;
    logic [8:0] in_box_y;
    logic [8:0] in_box_w;
    logic [8:0] in_box_h;
    logic [2:0] in_box_color;
    logic [8:0] pix_x;
    logic [8:0] pix_y;
    logic [2:0] pix_color;
    logic       pix_plot;

    modport master (
        input  s_ready, pix_x, pix_y, pix_color, pix_plot,
        output s_valid, in_box_x, in_box_y, in_box_w, in_box_h, in_box_color
    );

    modport slave (
        output s_ready, pix_x, pix_y, pix_color, pix_plot,
        input  s_valid, in_box_x, in_box_y, in_box_w, in_box_h, in_box_color
    );
endinterface

// File: rtl/box_drawer.sv
// Rasterises one accepted rectangle row-major, one pixel write per clock.
// Optional off-screen clipping of the plot strobe: define BOX_DRAWER_CLIP_EN.
module box_drawer #(
    parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
    parameter logic [8:0] SCREEN_HEIGHT = 9'd240
) (
    input  logic         clock,
    input  logic         reset,
    box_drawer_if.slave  bus
);

`ifdef BOX_DRAWER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_DRAW} state_t;

    state_t     state_q, state_d;
    logic [8:0] col_q, col_d;
    logic [8:0] row_q, row_d;
    logic [8:0] bx_q, bx_d;
    logic [8:0] by_q, by_d;
    logic [8:0] bw_q, bw_d;
    logic [8:0] bh_q, bh_d;
    logic [2:0] bc_q, bc_d;

    logic [9:0] sum_x, sum_y;
    logic       drawing, in_screen;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bw_d    = bw_q;
        bh_d    = bh_q;
        bc_d    = bc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.s_valid) begin
                    bx_d  = bus.in_box_x;
                    by_d  = bus.in_box_y;
                    bw_d  = bus.in_box_w;
                    bh_d  = bus.in_box_h;
                    bc_d  = bus.in_box_color;
                    col_d = '0;
                    row_d = '0;
                    // Degenerate boxes are consumed without emitting anything.
                    if (bus.in_box_w != '0 && bus.in_box_h != '0)
                        state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (col_q == bw_q - 9'd1) begin
                    col_d = '0;
                    if (row_q == bh_q - 9'd1)
                        state_d = S_IDLE;
                    else
                        row_d = row_q + 9'd1;
                end else begin
                    col_d = col_q + 9'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            bw_q    <= '0;
            bh_q    <= '0;
            bc_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bw_q    <= bw_d;
            bh_q    <= bh_d;
            bc_q    <= bc_d;
        end
    end

    // Reset gates the outputs directly so an in-flight box stops plotting immediately.
    assign sum_x     = {1'b0, bx_q} + {1'b0, col_q};
    assign sum_y     = {1'b0, by_q} + {1'b0, row_q};
    assign drawing   = (state_q == S_DRAW) && !reset;
    assign in_screen = (sum_x < {1'b0, SCREEN_WIDTH}) && (sum_y < {1'b0, SCREEN_HEIGHT});

    assign bus.s_ready   = (state_q == S_IDLE) && !reset;
    assign bus.pix_plot  = drawing && (!CLIP_EN || in_screen);
    assign bus.pix_x     = drawing ? sum_x[8:0] : 9'd0;
    assign bus.pix_y     = drawing ? sum_y[8:0] : 9'd0;
    assign bus.pix_color = drawing ? bc_q : 3'd0;

endmodule

// File: tb/tb_box_drawer.sv
// Directed bench: per-cycle vector table for reset/basic/degenerate boxes,
// plus hand sequences for full-screen clear, screen-edge wrap/clip and mid-draw reset.
module tb_box_drawer;
    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    box_drawer_if bus ();

    box_drawer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [8:0] x, y, w, h;
        logic [2:0] c;
        logic       e_rdy;
        logic       e_plot;
        logic [8:0] e_px, e_py;
        logic [2:0] e_pc;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(logic rst, logic vld, int x, int y, int w, int h, int c,
                                logic e_rdy, logic e_plot, int e_px, int e_py, int e_pc);
        vec_t v;
        v.rst = rst; v.vld = vld;
        v.x = 9'(x); v.y = 9'(y); v.w = 9'(w); v.h = 9'(h); v.c = 3'(c);
        v.e_rdy = e_rdy; v.e_plot = e_plot;
        v.e_px = 9'(e_px); v.e_py = 9'(e_py); v.e_pc = 3'(e_pc);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic vld, input int x, input int y, input int w, input int h, input int c);
        bus.s_valid      = vld;
        bus.in_box_x     = 9'(x);
        bus.in_box_y     = 9'(y);
        bus.in_box_w     = 9'(w);
        bus.in_box_h     = 9'(h);
        bus.in_box_color = 3'(c);
    endtask

    int cyc, plots, bad_col, lx, ly;
    int ex_x [8];
    int ex_y [8];
    int ex_p [8];

    initial begin
        reset = 1'b1;
        drive(1'b0, 0, 0, 0, 0, 0);

        //        rst  vld  x    y    w  h  c   rdy  plot px  py  pc
        tbl[0]  = mk(1, 0,   0,   0,  0, 0, 0,   0,   0,   0,  0,  0);
        tbl[1]  = mk(1, 1,   3,   5,  2, 2, 5,   0,   0,   0,  0,  0);
        tbl[2]  = mk(1, 0,   0,   0,  0, 0, 0,   0,   0,   0,  0,  0);
        tbl[3]  = mk(0, 1,   3,   5,  2, 2, 5,   1,   0,   0,  0,  0);
        tbl[4]  = mk(0, 0,   0,   0,  0, 0, 0,   0,   1,   3,  5,  5);
        tbl[5]  = mk(0, 1, 100, 100,  9, 9, 1,   0,   1,   4,  5,  5);
        tbl[6]  = mk(0, 1, 100, 100,  9, 9, 1,   0,   1,   3,  6,  5);
        tbl[7]  = mk(0, 0,   0,   0,  0, 0, 0,   0,   1,   4,  6,  5);
        tbl[8]  = mk(0, 1,   7,   7,  0, 7, 1,   1,   0,   0,  0,  0);
        tbl[9]  = mk(0, 1,  10,  20,  1, 1, 2,   1,   0,   0,  0,  0);
        tbl[10] = mk(0, 0,   0,   0,  0, 0, 0,   0,   1,  10, 20,  2);
        tbl[11] = mk(0, 0,   0,   0,  0, 0, 0,   1,   0,   0,  0,  0);

        @(negedge clock);
        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst;
            drive(tbl[i].vld, int'(tbl[i].x), int'(tbl[i].y), int'(tbl[i].w),
                  int'(tbl[i].h), int'(tbl[i].c));
            #1;
            chk($sformatf("v%0d s_ready", i),   int'(bus.s_ready),   int'(tbl[i].e_rdy));
            chk($sformatf("v%0d pix_plot", i),  int'(bus.pix_plot),  int'(tbl[i].e_plot));
            chk($sformatf("v%0d pix_x", i),     int'(bus.pix_x),     int'(tbl[i].e_px));
            chk($sformatf("v%0d pix_y", i),     int'(bus.pix_y),     int'(tbl[i].e_py));
            chk($sformatf("v%0d pix_color", i), int'(bus.pix_color), int'(tbl[i].e_pc));
            step();
        end

        // Full-screen clear
        drive(1'b1, 0, 0, 320, 240, 0);
        chk("clear ready before", int'(bus.s_ready), 1);
        step();
        drive(1'b0, 0, 0, 0, 0, 0);
        cyc = 0; plots = 0; bad_col = 0; lx = -1; ly = -1;
        while (bus.s_ready == 1'b0 && cyc < 80000) begin
            if (bus.pix_plot) begin
                plots++;
                lx = int'(bus.pix_x);
                ly = int'(bus.pix_y);
                if (bus.pix_color != 3'd0) bad_col++;
            end
            cyc++;
            step();
        end
        chk("clear timeout", int'(cyc < 80000), 1);
        chk("clear cycles", cyc, 76800);
        chk("clear plots", plots, 76800);
        chk("clear last x", lx, 319);
        chk("clear last y", ly, 239);
        chk("clear colour errs", bad_col, 0);

        // Screen-edge box: coordinates wrap past the edge, plot depends on clipping
        for (int i = 0; i < 8; i++) begin
            ex_x[i] = 318 + (i % 4);
            ex_y[i] = 239 + (i / 4);
`ifdef BOX_DRAWER_CLIP_EN
            ex_p[i] = (i < 2) ? 1 : 0;
`else
            ex_p[i] = 1;
`endif
        end
        drive(1'b1, 318, 239, 4, 2, 3);
        step();
        drive(1'b0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("edge%0d ready", i), int'(bus.s_ready), 0);
            chk($sformatf("edge%0d plot", i),  int'(bus.pix_plot), ex_p[i]);
            chk($sformatf("edge%0d x", i),     int'(bus.pix_x), ex_x[i]);
            chk($sformatf("edge%0d y", i),     int'(bus.pix_y), ex_y[i]);
            step();
        end
        chk("edge ready after", int'(bus.s_ready), 1);

        // Reset on the third pixel of a 10x10 box
        drive(1'b1, 50, 60, 10, 10, 7);
        step();
        drive(1'b0, 0, 0, 0, 0, 0);
        chk("rst pix1 x", int'(bus.pix_x), 50);
        chk("rst pix1 plot", int'(bus.pix_plot), 1);
        step();
        chk("rst pix2 x", int'(bus.pix_x), 51);
        step();
        chk("rst pix3 plot pre", int'(bus.pix_plot), 1);
        chk("rst pix3 x pre", int'(bus.pix_x), 52);
        reset = 1'b1;
        #1;
        chk("rst cycle plot", int'(bus.pix_plot), 0);
        chk("rst cycle ready", int'(bus.s_ready), 0);
        chk("rst cycle x", int'(bus.pix_x), 0);
        step();
        chk("rst hold plot", int'(bus.pix_plot), 0);
        reset = 1'b0;
        #1;
        chk("rst release ready", int'(bus.s_ready), 1);
        chk("rst release plot", int'(bus.pix_plot), 0);
        drive(1'b1, 1, 1, 1, 1, 6);
        step();
        drive(1'b0, 0, 0, 0, 0, 0);
        chk("post plot", int'(bus.pix_plot), 1);
        chk("post x", int'(bus.pix_x), 1);
        chk("post y", int'(bus.pix_y), 1);
        chk("post colour", int'(bus.pix_color), 6);
        chk("post ready low", int'(bus.s_ready), 0);
        step();
        chk("post ready back", int'(bus.s_ready), 1);
        chk("post plot done", int'(bus.pix_plot), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
